// File: rtl/wb_stage.sv
// Writeback pipeline register: stores the memory-stage result and selects register-file write data.
// Optional retired-instruction counter on o_instret, built only when WB_INSTRET_EN is defined.
module wb_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [4:0]            i_Rd,
  input  logic [DATA_WIDTH-1:0] i_MemOut,
  input  logic [DATA_WIDTH-1:0] i_DataOut,
  input  logic                  i_ctrl_RegWrite,
  input  logic                  i_ctrl_MemToReg,
  output logic                  o_RegWrite,
  output logic [4:0]            o_Rd,
  output logic [DATA_WIDTH-1:0] o_WriteData,
  output logic                  o_valid
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           o_instret
`endif
);

  logic                  valid_reg, valid_next;
  logic                  reg_write_reg, reg_write_next;
  logic                  mem_to_reg_reg, mem_to_reg_next;
  logic [4:0]            rd_reg, rd_next;
  logic [DATA_WIDTH-1:0] mem_out_reg, mem_out_next;
  logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;

  // A flush only kills valid/RegWrite; the data fields are held since a bubble never writes.
  always_comb begin
    valid_next      = valid_reg;
    reg_write_next  = reg_write_reg;
    mem_to_reg_next = mem_to_reg_reg;
    rd_next         = rd_reg;
    mem_out_next    = mem_out_reg;
    data_out_next   = data_out_reg;
    if (i_flush) begin
      valid_next     = 1'b0;
      reg_write_next = 1'b0;
    end else if (!i_stall) begin
      valid_next      = i_valid;
      reg_write_next  = i_ctrl_RegWrite;
      mem_to_reg_next = i_ctrl_MemToReg;
      rd_next         = i_Rd;
      mem_out_next    = i_MemOut;
      data_out_next   = i_DataOut;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_reg      <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      rd_reg         <= 5'd0;
      mem_out_reg    <= '0;
      data_out_reg   <= '0;
    end else begin
      valid_reg      <= valid_next;
      reg_write_reg  <= reg_write_next;
      mem_to_reg_reg <= mem_to_reg_next;
      rd_reg         <= rd_next;
      mem_out_reg    <= mem_out_next;
      data_out_reg   <= data_out_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_wdata
      assign o_WriteData[gi] = mem_to_reg_reg ? mem_out_reg[gi] : data_out_reg[gi];
    end
  endgenerate

  // x0 is hardwired to zero, so a write to it is suppressed here rather than in the register file.
  assign o_RegWrite = valid_reg & reg_write_reg & (rd_reg != 5'd0);
  assign o_Rd       = rd_reg;
  assign o_valid    = valid_reg;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_reg, instret_next;

  // The instruction leaving the register retires even if a flush replaces it with a bubble.
  always_comb begin
    instret_next = instret_reg;
    if (valid_reg && !i_stall) instret_next = instret_reg + 64'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) instret_reg <= 64'd0;
    else        instret_reg <= instret_next;
  end

  assign o_instret = instret_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against
// a behavioural model of the stored instruction.
module tb_wb_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_valid, i_stall, i_flush;
  logic [4:0]    i_Rd;
  logic [DW-1:0] i_MemOut, i_DataOut;
  logic          i_ctrl_RegWrite, i_ctrl_MemToReg;
  logic          o_RegWrite;
  logic [4:0]    o_Rd;
  logic [DW-1:0] o_WriteData;
  logic          o_valid;
`ifdef WB_INSTRET_EN
  logic [63:0]   o_instret;
`endif

  int checks = 0;
  int errors = 0;

  // Model: what the writeback slot holds, described by its architectural meaning.
  bit            m_v, m_we, m_known;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_wd;
  longint unsigned m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_Rd(i_Rd), .i_MemOut(i_MemOut), .i_DataOut(i_DataOut),
    .i_ctrl_RegWrite(i_ctrl_RegWrite), .i_ctrl_MemToReg(i_ctrl_MemToReg),
    .o_RegWrite(o_RegWrite), .o_Rd(o_Rd), .o_WriteData(o_WriteData), .o_valid(o_valid)
`ifdef WB_INSTRET_EN
    , .o_instret(o_instret)
`endif
  );

  function automatic bit exp_we();
    return m_v && m_we && (m_rd != 5'd0);
  endfunction

  task automatic model_reset();
    m_v = 0; m_we = 0; m_rd = 0; m_wd = 0; m_known = 1; m_cnt = 0;
  endtask

  task automatic drive(input bit v, input bit we, input bit mtr, input logic [4:0] rd,
                       input logic [DW-1:0] mem, input logic [DW-1:0] dat,
                       input bit stall, input bit flush);
    i_valid = v; i_ctrl_RegWrite = we; i_ctrl_MemToReg = mtr; i_Rd = rd;
    i_MemOut = mem; i_DataOut = dat; i_stall = stall; i_flush = flush;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge clk);
    if (m_v && !i_stall) m_cnt++;
    if (i_flush) begin
      m_v = 0; m_we = 0; m_known = 0;
    end else if (!i_stall) begin
      m_v = i_valid; m_we = i_ctrl_RegWrite; m_rd = i_Rd;
      m_wd = i_ctrl_MemToReg ? i_MemOut : i_DataOut; m_known = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    checks++;
    if (o_RegWrite !== 1'b0 || o_Rd !== 5'd0 || o_WriteData !== '0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got we=%b rd=%0d wd=%h v=%b, want all 0",
               o_RegWrite, o_Rd, o_WriteData, o_valid);
    end
    @(negedge clk);
    #2 n_rst = 1'b1;
    drive(1, 1, 0, 5'd4, 32'h0, 32'hCAFE_0001, 0, 0);
    tick();
    checks++;
    if (o_RegWrite !== 1'b1 || o_Rd !== 5'd4 || o_WriteData !== 32'hCAFE_0001 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: got we=%b rd=%0d wd=%h v=%b, want 1 4 cafe0001 1",
               o_RegWrite, o_Rd, o_WriteData, o_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu_load();
    drive(1, 1, 0, 5'd5, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0);
    tick();
    checks++;
    if (o_RegWrite !== 1'b1 || o_Rd !== 5'd5 || o_WriteData !== 32'h0000_1234) begin
      errors++;
      $display("FAIL alu_wb: got we=%b rd=%0d wd=%h, want 1 5 00001234", o_RegWrite, o_Rd, o_WriteData);
    end
    drive(1, 1, 1, 5'd7, 32'hFFFF_FF80, 32'h5555_AAAA, 0, 0);
    tick();
    checks++;
    if (o_RegWrite !== 1'b1 || o_Rd !== 5'd7 || o_WriteData !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL load_wb: got we=%b rd=%0d wd=%h, want 1 7 ffffff80", o_RegWrite, o_Rd, o_WriteData);
    end
    $display("test_alu_load done");
  endtask

  task automatic test_x0_bubble();
    drive(1, 1, 0, 5'd0, 0, 32'h1111_2222, 0, 0);
    tick();
    checks++;
    if (o_RegWrite !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL x0_suppress: got we=%b v=%b, want 0 1", o_RegWrite, o_valid);
    end
    drive(0, 1, 0, 5'd3, 0, 32'h3333_4444, 0, 0);
    tick();
    checks++;
    if (o_RegWrite !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got we=%b v=%b, want 0 0", o_RegWrite, o_valid);
    end
    $display("test_x0_bubble done");
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 0, 5'd9, 32'h0, 32'h0009_0009, 0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 1, 5'd12, 32'hAAAA_0000 + c, 32'hBBBB_0000 + c, 1, 0);
      tick();
      checks++;
      if (o_RegWrite !== 1'b1 || o_Rd !== 5'd9 || o_WriteData !== 32'h0009_0009 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got we=%b rd=%0d wd=%h v=%b, want 1 9 00090009 1",
                 c, o_RegWrite, o_Rd, o_WriteData, o_valid);
      end
    end
    drive(1, 1, 0, 5'd12, 0, 32'h1, 1, 1);
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall: got v=%b we=%b, want 0 0", o_valid, o_RegWrite);
    end
    $display("test_stall_flush done");
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 5'd17, 0, 32'h7777_8888, 0, 0);
    tick();
    checks++;
    if (o_RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_we: got we=%b, want 1", o_RegWrite);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (o_RegWrite !== 1'b0 || o_Rd !== 5'd0 || o_WriteData !== '0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got we=%b rd=%0d wd=%h v=%b, want all 0",
               o_RegWrite, o_Rd, o_WriteData, o_valid);
    end
    model_reset();
    @(negedge clk);
    #1 n_rst = 1'b1;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (o_valid !== m_v || o_RegWrite !== exp_we()) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got v=%b we=%b, want v=%b we=%b", n, o_valid, o_RegWrite, m_v, exp_we());
      end
      if (m_known) begin
        checks++;
        if (o_Rd !== m_rd || o_WriteData !== m_wd) begin
          errors++;
          $display("FAIL rand_data[%0d]: got rd=%0d wd=%h, want rd=%0d wd=%h", n, o_Rd, o_WriteData, m_rd, m_wd);
        end
      end
`ifdef WB_INSTRET_EN
      checks++;
      if (o_instret !== m_cnt) begin
        errors++;
        $display("FAIL rand_instret[%0d]: got %0d, want %0d", n, o_instret, m_cnt);
      end
`endif
    end
    $display("test_random done");
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret();
    @(negedge clk);
    n_rst = 1'b0;
    model_reset();
    #2 n_rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(k < 10, 1, 0, 5'(k + 1), 0, k, 0, 0);
      tick();
      if (k == 4) begin
        for (int s = 0; s < 3; s++) begin
          drive(1, 1, 0, 5'd20, 0, 0, 1, 0);
          tick();
        end
      end
    end
    checks++;
    if (o_instret !== 64'd10) begin
      errors++;
      $display("FAIL instret_count: got %0d, want 10", o_instret);
    end
    drive(1, 1, 0, 5'd2, 0, 32'h2, 0, 0);
    tick();
    dut.instret_reg = '1;
    m_cnt = '1;
    drive(0, 0, 0, 5'd0, 0, 0, 0, 1);
    tick();
    checks++;
    if (o_instret !== 64'd0) begin
      errors++;
      $display("FAIL instret_wrap: got %0d, want 0", o_instret);
    end
    $display("test_instret done");
  endtask
`endif

  initial begin
    test_reset();
    test_alu_load();
    test_x0_bubble();
    test_stall_flush();
    test_reset_mid();
    test_random();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
